// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory port between the CPU control unit and the debug/loader port, with round-robin on contention.
// Latency: req seen in IDLE cycle 0 -> fault ack cycle 1, write ack cycle 2, read ack cycle 2+MEM_LAT.
// Backpressure: requesters hold req with stable fields until their one-cycle ack; requests are sampled only in IDLE.
module mem_bus_arbiter #(
    // Cycles from the mem_rd strobe to valid mem_rdata; legal range 1..7.
    parameter int MEM_LAT = 1
) (
    input  logic        i_core_clk,
    input  logic        i_rst,

    // CPU control unit requester
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic        i_cpu_byte,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic        o_cpu_err,
    output logic [15:0] o_cpu_rdata,

    // Front-panel debug/loader requester
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic        i_dbg_byte,
    input  logic [15:0] i_dbg_addr,
    input  logic [15:0] i_dbg_wdata,
    output logic        o_dbg_ack,
    output logic        o_dbg_err,
    output logic [15:0] o_dbg_rdata,

    // Memory port
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic [1:0]  o_mem_be,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic [15:0] i_mem_rdata,

    // Status
    output logic        o_gnt_dbg,
    output logic        o_busy
);

    // Wait-counter load value; MEM_LAT is limited to 1..7 so it fits in 3 bits.
    localparam logic [2:0] LP_LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched transaction of the current owner.
    logic        r_owner_dbg;
    logic        r_last_dbg;
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_err;
    logic [2:0]  r_cnt;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dbg_rdata;

    // Arbitration and winner field selection (only meaningful in IDLE).
    logic        w_grant_vld;
    logic        w_grant_dbg;
    logic        w_win_we;
    logic        w_win_byte;
    logic [15:0] w_win_addr;
    logic [15:0] w_win_wdata;
    logic        w_win_fault;
    logic        w_rd_done;
    logic [15:0] w_rd_lane;

    // Pick the winner: a lone requester wins outright, a tie goes to whoever was not granted last.
    always_comb begin
        w_grant_vld = i_cpu_req | i_dbg_req;
        w_grant_dbg = i_dbg_req & (~i_cpu_req | ~r_last_dbg);
        w_win_we    = w_grant_dbg ? i_dbg_we    : i_cpu_we;
        w_win_byte  = w_grant_dbg ? i_dbg_byte  : i_cpu_byte;
        w_win_addr  = w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
        w_win_wdata = w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
        // A word access on an odd address never reaches memory.
        w_win_fault = ~w_win_byte & w_win_addr[0];
    end

    // Read data becomes valid in the last WAIT cycle; byte reads return the addressed lane zero-extended.
    always_comb begin
        w_rd_done = (r_state == ST_WAIT) && (r_cnt <= 3'd1);
        w_rd_lane = i_mem_rdata;
        if (r_byte) begin
            w_rd_lane = {8'h00, (r_addr[0] ? i_mem_rdata[15:8] : i_mem_rdata[7:0])};
        end
    end

    // State register.
    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE, faults skip straight to RESP.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = w_win_fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = r_we ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rd_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's fields and ownership at the grant edge; last-owner starts as DBG so CPU wins the first tie.
    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_owner_dbg <= 1'b0;
            r_last_dbg  <= 1'b1;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_err       <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_grant_vld) begin
            r_owner_dbg <= w_grant_dbg;
            r_last_dbg  <= w_grant_dbg;
            r_we        <= w_win_we;
            r_byte      <= w_win_byte;
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_err       <= w_win_fault;
        end
    end

    // Read latency counter: loaded as the read strobe goes out, counts down through WAIT.
    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_cnt <= 3'd0;
        end else if ((r_state == ST_ACCESS) && !r_we) begin
            r_cnt <= LP_LAT;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Capture read data into the owner's holding register so it appears together with the ack and holds afterwards.
    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_cpu_rdata <= 16'h0000;
            r_dbg_rdata <= 16'h0000;
        end else if (w_rd_done) begin
            if (r_owner_dbg) begin
                r_dbg_rdata <= w_rd_lane;
            end else begin
                r_cpu_rdata <= w_rd_lane;
            end
        end
    end

    // Drive the memory strobes only in ACCESS and the owner's ack only in RESP; everything else idles at zero.
    always_comb begin
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 16'h0000;
        o_mem_be    = 2'b00;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_cpu_ack   = 1'b0;
        o_cpu_err   = 1'b0;
        o_dbg_ack   = 1'b0;
        o_dbg_err   = 1'b0;
        if (r_state == ST_ACCESS) begin
            o_mem_addr = {r_addr[15:1], 1'b0};
            o_mem_rd   = ~r_we;
            o_mem_wr   = r_we;
            if (r_byte) begin
                o_mem_be    = r_addr[0] ? 2'b10 : 2'b01;
                o_mem_wdata = {r_wdata[7:0], r_wdata[7:0]};
            end else begin
                o_mem_be    = 2'b11;
                o_mem_wdata = r_wdata;
            end
        end
        if (r_state == ST_RESP) begin
            o_cpu_ack = ~r_owner_dbg;
            o_cpu_err = ~r_owner_dbg & r_err;
            o_dbg_ack = r_owner_dbg;
            o_dbg_err = r_owner_dbg & r_err;
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_gnt_dbg   = r_owner_dbg;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        dbg_req, dbg_we, dbg_byte;
    logic [15:0] dbg_addr, dbg_wdata;
    logic [15:0] mem_val;

    // Instance A: MEM_LAT=1
    logic        a_cpu_ack, a_cpu_err, a_dbg_ack, a_dbg_err;
    logic [15:0] a_cpu_rdata, a_dbg_rdata;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_mem_be;
    logic        a_mem_rd, a_mem_wr, a_gnt_dbg, a_busy;

    // Instance B: MEM_LAT=3
    logic        b_cpu_ack, b_cpu_err, b_dbg_ack, b_dbg_err;
    logic [15:0] b_cpu_rdata, b_dbg_rdata;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_mem_be;
    logic        b_mem_rd, b_mem_wr, b_gnt_dbg, b_busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.MEM_LAT(1)) u_dut_lat1 (
        .i_core_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_byte(cpu_byte),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(a_cpu_ack), .o_cpu_err(a_cpu_err), .o_cpu_rdata(a_cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_byte(dbg_byte),
        .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ack(a_dbg_ack), .o_dbg_err(a_dbg_err), .o_dbg_rdata(a_dbg_rdata),
        .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .o_mem_be(a_mem_be),
        .o_mem_rd(a_mem_rd), .o_mem_wr(a_mem_wr), .i_mem_rdata(a_mem_rdata),
        .o_gnt_dbg(a_gnt_dbg), .o_busy(a_busy)
    );

    mem_bus_arbiter #(.MEM_LAT(3)) u_dut_lat3 (
        .i_core_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_byte(cpu_byte),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(b_cpu_ack), .o_cpu_err(b_cpu_err), .o_cpu_rdata(b_cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_byte(dbg_byte),
        .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ack(b_dbg_ack), .o_dbg_err(b_dbg_err), .o_dbg_rdata(b_dbg_rdata),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_be(b_mem_be),
        .o_mem_rd(b_mem_rd), .o_mem_wr(b_mem_wr), .i_mem_rdata(b_mem_rdata),
        .o_gnt_dbg(b_gnt_dbg), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data is valid only in the cycle exactly MEM_LAT after the strobe, garbage otherwise.
    logic [2:0] a_hist, b_hist;
    always @(posedge clk) begin
        if (rst) begin
            a_hist <= 3'b000;
            b_hist <= 3'b000;
        end else begin
            a_hist <= {a_hist[1:0], a_mem_rd};
            b_hist <= {b_hist[1:0], b_mem_rd};
        end
    end
    assign a_mem_rdata = a_hist[0] ? mem_val : 16'hDEAD;
    assign b_mem_rdata = b_hist[2] ? mem_val : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // T1: reset held two cycles with both requests high
        rst = 1'b1; mem_val = 16'h0000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 16'h5555;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_byte = 1'b0; dbg_addr = 16'h0300; dbg_wdata = 16'h6666;
        tick();
        tick();
        chk1("rst_mem_rd", a_mem_rd, 1'b0);
        chk1("rst_mem_wr", a_mem_wr, 1'b0);
        chk1("rst_cpu_ack", a_cpu_ack, 1'b0);
        chk1("rst_dbg_ack", a_dbg_ack, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_gnt_dbg", a_gnt_dbg, 1'b0);
        chk16("rst_mem_addr", a_mem_addr, 16'h0000);
        chk16("rst_mem_be", {14'd0, a_mem_be}, 16'h0000);
        chk16("rst_cpu_rdata", a_cpu_rdata, 16'h0000);
        chk1("rst_b_busy", b_busy, 1'b0);
        rst = 1'b0;
        tick();                                             // c1: first tie goes to CPU
        chk1("t1_tie_mem_wr", a_mem_wr, 1'b1);
        chk1("t1_tie_gnt_dbg", a_gnt_dbg, 1'b0);
        chk16("t1_tie_addr", a_mem_addr, 16'h0200);
        chk16("t1_tie_wdata", a_mem_wdata, 16'h5555);
        chk16("t1_tie_be", {14'd0, a_mem_be}, 16'h0003);
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick();                                             // c2: write ack
        chk1("t1_cpu_ack", a_cpu_ack, 1'b1);
        chk1("t1_dbg_ack", a_dbg_ack, 1'b0);
        chk1("t1_cpu_err", a_cpu_err, 1'b0);
        tick();                                             // c3: back in IDLE
        chk1("t1_idle", a_busy, 1'b0);

        // T2: CPU word read 0x0100, MEM_LAT=1 on A and MEM_LAT=3 on B, req dropped after grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0100; mem_val = 16'h1234;
        tick();                                             // c1
        cpu_req = 1'b0;
        chk1("t2_mem_rd", a_mem_rd, 1'b1);
        chk1("t2_mem_wr", a_mem_wr, 1'b0);
        chk16("t2_mem_addr", a_mem_addr, 16'h0100);
        chk16("t2_mem_be", {14'd0, a_mem_be}, 16'h0003);
        chk1("t2_b_mem_rd", b_mem_rd, 1'b1);
        tick();                                             // c2
        chk1("t2_c2_ack", a_cpu_ack, 1'b0);
        chk1("t2_c2_busy", a_busy, 1'b1);
        tick();                                             // c3
        chk1("t2_ack", a_cpu_ack, 1'b1);
        chk1("t2_err", a_cpu_err, 1'b0);
        chk16("t2_rdata", a_cpu_rdata, 16'h1234);
        chk1("t2_b_c3_ack", b_cpu_ack, 1'b0);
        tick();                                             // c4
        chk1("t2_c4_ack", a_cpu_ack, 1'b0);
        chk16("t2_rdata_hold", a_cpu_rdata, 16'h1234);
        chk1("t2_b_c4_ack", b_cpu_ack, 1'b0);
        tick();                                             // c5
        chk1("t2_b_ack", b_cpu_ack, 1'b1);
        chk16("t2_b_rdata", b_cpu_rdata, 16'h1234);
        tick();                                             // c6
        chk1("t2_b_idle", b_busy, 1'b0);

        // T3: debug byte write to odd address 0x0105
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_byte = 1'b1; dbg_addr = 16'h0105; dbg_wdata = 16'h00AB;
        tick();                                             // c1
        dbg_req = 1'b0;
        chk1("t3_mem_wr", a_mem_wr, 1'b1);
        chk1("t3_mem_rd", a_mem_rd, 1'b0);
        chk16("t3_mem_addr", a_mem_addr, 16'h0104);
        chk16("t3_mem_be", {14'd0, a_mem_be}, 16'h0002);
        chk16("t3_mem_wdata", a_mem_wdata, 16'hABAB);
        chk1("t3_gnt_dbg", a_gnt_dbg, 1'b1);
        tick();                                             // c2
        chk1("t3_dbg_ack", a_dbg_ack, 1'b1);
        chk1("t3_cpu_ack", a_cpu_ack, 1'b0);
        chk1("t3_dbg_err", a_dbg_err, 1'b0);
        tick();                                             // c3

        // T4: byte reads of both lanes, mem returns 0xCD12
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b1; cpu_addr = 16'h0105; mem_val = 16'hCD12;
        tick();
        cpu_req = 1'b0;
        chk1("t4_hi_mem_rd", a_mem_rd, 1'b1);
        chk16("t4_hi_be", {14'd0, a_mem_be}, 16'h0002);
        chk16("t4_hi_addr", a_mem_addr, 16'h0104);
        tick();
        tick();
        chk1("t4_hi_ack", a_cpu_ack, 1'b1);
        chk16("t4_hi_rdata", a_cpu_rdata, 16'h00CD);
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_byte = 1'b1; dbg_addr = 16'h0104;
        tick();
        dbg_req = 1'b0;
        chk16("t4_lo_be", {14'd0, a_mem_be}, 16'h0001);
        chk16("t4_lo_addr", a_mem_addr, 16'h0104);
        tick();
        tick();
        chk1("t4_lo_ack", a_dbg_ack, 1'b1);
        chk1("t4_lo_cpu_ack", a_cpu_ack, 1'b0);
        chk16("t4_lo_rdata", a_dbg_rdata, 16'h0012);
        chk16("t4_cpu_rdata_kept", a_cpu_rdata, 16'h00CD);
        tick();

        // T5: both requesters hold write requests continuously; grants alternate starting with CPU
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_byte = 1'b0; dbg_addr = 16'h0020; dbg_wdata = 16'h2222;
        for (int c = 0; c < 12; c++) begin
            chk1("t5_mem_wr", a_mem_wr, (c % 3) == 1);
            chk1("t5_cpu_ack", a_cpu_ack, (c % 6) == 2);
            chk1("t5_dbg_ack", a_dbg_ack, (c % 6) == 5);
            if ((c % 3) == 1) begin
                chk1("t5_gnt_dbg", a_gnt_dbg, (c % 6) == 4);
                chk16("t5_mem_addr", a_mem_addr, ((c % 6) == 1) ? 16'h0010 : 16'h0020);
                chk16("t5_mem_wdata", a_mem_wdata, ((c % 6) == 1) ? 16'h1111 : 16'h2222);
            end
            if (c == 11) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            tick();
        end
        chk1("t5_idle", a_busy, 1'b0);

        // T6: misaligned CPU word read faults without a memory cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0101;
        tick();                                             // c1
        cpu_req = 1'b0;
        chk1("t6_fault_ack", a_cpu_ack, 1'b1);
        chk1("t6_fault_err", a_cpu_err, 1'b1);
        chk1("t6_fault_no_rd", a_mem_rd, 1'b0);
        chk1("t6_fault_dbg_ack", a_dbg_ack, 1'b0);
        chk16("t6_fault_rdata", a_cpu_rdata, 16'h00CD);
        tick();                                             // c2
        chk1("t6_fault_done", a_cpu_ack, 1'b0);
        chk1("t6_fault_idle", a_busy, 1'b0);

        // T6: reset while a CPU read sits in WAIT discards it and restores DBG as last owner
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0200; mem_val = 16'hBEEF;
        tick();                                             // c1 ACCESS
        cpu_req = 1'b0;
        chk1("t6_rd_strobe", a_mem_rd, 1'b1);
        tick();                                             // c2 WAIT
        chk1("t6_wait_busy", a_busy, 1'b1);
        rst = 1'b1;
        tick();                                             // c3
        rst = 1'b0;
        chk1("t6_rst_idle", a_busy, 1'b0);
        chk1("t6_rst_ack", a_cpu_ack, 1'b0);
        chk1("t6_rst_rd", a_mem_rd, 1'b0);
        chk16("t6_rst_rdata", a_cpu_rdata, 16'h0000);
        tick();                                             // c4
        chk1("t6_no_late_ack", a_cpu_ack, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0400; cpu_wdata = 16'h4444;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_byte = 1'b0; dbg_addr = 16'h0500; dbg_wdata = 16'h5555;
        tick();
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk1("t6_tie_gnt_dbg", a_gnt_dbg, 1'b0);
        chk1("t6_tie_mem_wr", a_mem_wr, 1'b1);
        chk16("t6_tie_addr", a_mem_addr, 16'h0400);
        tick();
        chk1("t6_tie_cpu_ack", a_cpu_ack, 1'b1);
        chk1("t6_tie_dbg_ack", a_dbg_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
